timing_sequencer: RTL and testbench

TIMING_SEQUENCER -- requirements
Module: timing_sequencer

---
 rtl/timing_sequencer.sv | 104 ++++++++++
 tb/tb_timing_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/timing_sequencer.sv
// timing_sequencer: one-hot timing-state generator T0..T(NUM_STATES-1) with
// a two-state RUN/HALT controller, synchronous clear and a wrap pulse.
// Optional feature: define TIMING_SEQ_LIMIT_EN to add the t_limit input,
// which lowers the terminal state to min(t_limit, NUM_STATES-1).
// Every output is driven from registers; inputs only feed next-state logic.
module timing_sequencer #(
  parameter int NUM_STATES = 8,
  parameter int CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clr,
  input  logic                  halt,
  input  logic                  resume,
`ifdef TIMING_SEQ_LIMIT_EN
  input  logic [CNT_W-1:0]      t_limit,
`endif
  output logic [NUM_STATES-1:0] t_out,
  output logic [CNT_W-1:0]      t_idx,
  output logic                  wrap,
  output logic                  halted
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] TERM_MAX = CNT_W'(NUM_STATES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_idx;
  logic             r_wrap;

  state_t           w_state_next;
  logic [CNT_W-1:0] w_idx_next;
  logic             w_wrap_next;
  logic [CNT_W-1:0] w_term;

`ifdef TIMING_SEQ_LIMIT_EN
  // Terminal state follows the live limit, clamped to the last legal state.
  assign w_term = (t_limit < TERM_MAX) ? t_limit : TERM_MAX;
`else
  assign w_term = TERM_MAX;
`endif

  // State, index and wrap registers; reset overrides everything on its edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RUN;
      r_idx   <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_wrap  <= w_wrap_next;
    end
  end

  // Next-state logic with priority clr > halt > resume > enable.
  // Using >= against the terminal state means an index stranded above a
  // freshly lowered limit wraps on the next enabled edge instead of running on.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_wrap_next  = 1'b0;
    if (clr) begin
      w_state_next = S_RUN;
      w_idx_next   = '0;
    end else if (halt) begin
      w_state_next = S_HALT;
    end else begin
      case (r_state)
        S_HALT: begin
          if (resume) begin
            w_state_next = S_RUN;
          end
        end
        default: begin
          if (enable) begin
            if (r_idx >= w_term) begin
              w_idx_next  = '0;
              w_wrap_next = 1'b1;
            end else begin
              w_idx_next = r_idx + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  // One-hot decode of the registered index; exactly one bit is ever set
  // because the index never leaves 0..NUM_STATES-1.
  for (genvar gi = 0; gi < NUM_STATES; gi++) begin : g_dec
    assign t_out[gi] = (r_idx == CNT_W'(gi));
  end

  assign t_idx  = r_idx;
  assign wrap   = r_wrap;
  assign halted = (r_state == S_HALT);

endmodule

// File: tb/tb_timing_sequencer.sv
// Testbench for timing_sequencer: an 8-state and a 5-state instance share the
// same stimulus and are checked every cycle against a behavioural model.
// Honours TIMING_SEQ_LIMIT_EN when defined.
module tb_timing_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, enable = 1'b0, clr = 1'b0, halt = 1'b0, resume = 1'b0;
  logic [2:0] t_limit = 3'd7;

  logic [7:0] a_t_out;
  logic [2:0] a_t_idx;
  logic       a_wrap, a_halted;
  logic [4:0] b_t_out;
  logic [2:0] b_t_idx;
  logic       b_wrap, b_halted;

  timing_sequencer #(.NUM_STATES(8), .CNT_W(3)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .clr(clr), .halt(halt), .resume(resume),
`ifdef TIMING_SEQ_LIMIT_EN
    .t_limit(t_limit),
`endif
    .t_out(a_t_out), .t_idx(a_t_idx), .wrap(a_wrap), .halted(a_halted)
  );

  timing_sequencer #(.NUM_STATES(5), .CNT_W(3)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .clr(clr), .halt(halt), .resume(resume),
`ifdef TIMING_SEQ_LIMIT_EN
    .t_limit(t_limit),
`endif
    .t_out(b_t_out), .t_idx(b_t_idx), .wrap(b_wrap), .halted(b_halted)
  );

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Behavioural model state per instance: 0 = 8 states, 1 = 5 states.
  int nst[2]     = '{8, 5};
  int m_idx[2]   = '{0, 0};
  bit m_halt[2]  = '{0, 0};
  bit m_wrap[2]  = '{0, 0};

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, obs, exp);
    end
  endtask

  // One clock edge of the reference behaviour, from the rules directly.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int term;
      term = nst[k] - 1;
`ifdef TIMING_SEQ_LIMIT_EN
      if (int'(t_limit) < term) term = int'(t_limit);
`endif
      m_wrap[k] = 1'b0;
      if (reset || clr) begin
        m_idx[k]  = 0;
        m_halt[k] = 1'b0;
      end else if (halt) begin
        m_halt[k] = 1'b1;
      end else if (m_halt[k]) begin
        if (resume) m_halt[k] = 1'b0;
      end else if (enable) begin
        if (m_idx[k] >= term) begin
          m_idx[k]  = 0;
          m_wrap[k] = 1'b1;
        end else begin
          m_idx[k] = m_idx[k] + 1;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("a_idx",    int'(a_t_idx),  m_idx[0]);
    chk("a_out",    int'(a_t_out),  1 << m_idx[0]);
    chk("a_wrap",   int'(a_wrap),   int'(m_wrap[0]));
    chk("a_halted", int'(a_halted), int'(m_halt[0]));
    chk("b_idx",    int'(b_t_idx),  m_idx[1]);
    chk("b_out",    int'(b_t_out),  1 << m_idx[1]);
    chk("b_onehot", int'($onehot(b_t_out)), 1);
    chk("b_wrap",   int'(b_wrap),   int'(m_wrap[1]));
    chk("b_halted", int'(b_halted), int'(m_halt[1]));
  endtask

  // Drive one set of inputs for one edge, then check after the edge.
  task automatic step(input bit r, input bit en, input bit c, input bit h, input bit rs);
    reset = r; enable = en; clr = c; halt = h; resume = rs;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    check_all();
    $display("cyc=%0d rst=%0d en=%0d clr=%0d halt=%0d res=%0d lim=%0d | a_idx=%0d a_wrap=%0d a_h=%0d b_idx=%0d b_wrap=%0d",
             cyc, r, en, c, h, rs, t_limit, a_t_idx, a_wrap, a_halted, b_t_idx, b_wrap);
  endtask

  int wraps;

  initial begin
    @(negedge clk);

    // Reset state.
    step(1, 0, 0, 0, 0);
    chk("rst_out", int'(a_t_out), 1);

    // Enable held 17 cycles: two wraps on the 8-state instance.
    wraps = 0;
    for (int i = 0; i < 17; i++) begin
      step(0, 1, 0, 0, 0);
      if (a_wrap) wraps++;
    end
    chk("wrap_cnt", wraps, 2);

    // Clear at T5 with enable high.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    chk("clr_idx", int'(a_t_idx), 0);

    // Halt at T3, enable ignored while halted, resume does not advance.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    chk("halt_hold", int'(a_t_idx), 3);
    step(0, 1, 0, 0, 1);
    chk("resume_noadv", int'(a_t_idx), 3);
    step(0, 1, 0, 0, 0);
    chk("resume_adv", int'(a_t_idx), 4);

    // Resume in RUN is a no-op: enable still advances.
    step(0, 1, 0, 0, 1);

    // Halt and clear on the same edge at T6; reset while halted at T2.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(1, 1, 0, 1, 1);

`ifdef TIMING_SEQ_LIMIT_EN
    // Programmable limit 3, then lowered to 1 while sitting at T3.
    t_limit = 3'd3;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 0);
    while (a_t_idx != 3'd3 && cyc < 2000) step(0, 1, 0, 0, 0);
    t_limit = 3'd1;
    step(0, 1, 0, 0, 0);
    chk("lim_wrap", int'(a_wrap), 1);
    t_limit = 3'd7;
`endif

    // Randomised phase with biased control inputs.
    for (int i = 0; i < 300; i++) begin
`ifdef TIMING_SEQ_LIMIT_EN
      if ($urandom_range(0, 15) == 0) t_limit = 3'($urandom_range(0, 7));
`endif
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 11) == 0,
           $urandom_range(0, 5) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
